dup_range_param: RTL and testbench
==================================

Name: dup_range_param

Overview:
- Parametrised successor of the two-value range re-yielder generator.
- Walks a Python-style `range(base, limit, step)` internally and yields each element COPIES times as a tuple `(value, copy_index)`.
- Handles positive and negative steps, zero step and signed overflow of the iterator.
- Sits behind a caller using the standard generator ready/valid/done handshake, and is instantiable as a function instance inside other generated modules.

Parameters:
- WIDTH, 32, signed width of `base`/`limit`/`step` and of `_0`.
- COPIES, 2, yields per range element (1..255).
- IDXW, 8, width of `_1` (copy index); must satisfy 2^IDXW >= COPIES.

Ports:
- `_clock`  in  1  clock; all state updates on its rising edge.
- `_reset`  in  1  synchronous, active-high reset.
- `_start`  in  1  capture inputs this cycle and begin generating.
- `base`  in  WIDTH  signed first element.
- `limit`  in  WIDTH  signed exclusive bound.
- `step`  in  WIDTH  signed increment.
- `_ready`  in  1  caller can accept output.
- `_valid`  out  1  `_0`/`_1` hold a valid tuple.
- `_done`  out  1  generator exhausted.
- `_0`  out  WIDTH  signed current range element.
- `_1`  out  IDXW  copy index, 0..COPIES-1.

Behaviour:
- Reset values, applied when `_reset` is high and `_start` is low:
  - state = DONE, `_valid` = 0, `_done` = 0, `_0` = 0, `_1` = 0, internal i/k = 0.
  - `_done` rises on the next edge via the DONE rule below.
- Precedence: `_start` overrides `_reset` in the same cycle.
- `_start`:
  - Latches base/limit/step, sets i = base, k = 0, `_valid` = 0, `_done` = 0, state = CHECK.
  - Allowed at any time; mid-run it abandons the current sequence and discards any unaccepted output.
- Advance condition: the FSM advances only on edges where `(_ready || !_valid)`; otherwise all state and outputs hold.
- Output handshake:
  - A tuple is transferred on an edge where `_valid && _ready`.
  - On that edge `_valid` either reloads with the next tuple or clears.
  - `_0`/`_1` are stable while `_valid && !_ready`.
- States:
  - CHECK:
    - Terminate when step == 0, OR step > 0 and i >= limit, OR step < 0 and i <= limit, OR the overflow flag is set. On terminate, state -> DONE.
    - Otherwise k = 0 and state -> EMIT.
  - EMIT:
    - Drive `_0` = i, `_1` = k, `_valid` = 1.
    - If k == COPIES-1: i <= i + step, overflow flag <= signed overflow of (i + step) computed at WIDTH+1 bits, state -> CHECK.
    - Else k <= k+1 and stay in EMIT.
  - DONE:
    - `_done` <= 1 on each advancing edge; `_valid` <= 0. Stays in DONE until `_start`.
    - `_done` is never high while an unaccepted tuple is valid.
- Latency:
  - `_start` sampled at edge E0 -> CHECK at E1 -> first `_valid` visible after E2.
  - With `_ready` held high: one tuple per cycle within a group of COPIES, plus one bubble cycle (CHECK) between groups.
- Overflow: a wrapped i must never be emitted; sequence ends even if the wrapped value would satisfy the bound test.
- The overflow flag is cleared on `_start` and on `_reset`.
- Arithmetic: comparisons are signed at WIDTH bits; `_1` is zero-extended k.

Test Plan:
- COPIES=2, (0,10,2), `_ready`=1 -> `_0`: 0,0,2,2,4,4,6,6,8,8; `_1`: 0,1 alternating; first `_valid` 2 cycles after start; then `_valid`=0, `_done`=1 held.
- COPIES=1, (10,0,-3) -> 10,7,4,1 then done; (5,5,1) -> no `_valid`, `_done` after 2 cycles.
- step=0, (3,9,0) -> zero tuples, `_done`=1; no hang.
- WIDTH=8, COPIES=1, (100,127,20) -> 100,120 then done; -116 never appears.
- Backpressure: (0,6,2), COPIES=2, `_ready` toggled 1,0,0,1,... -> exact sequence 0,0,2,2,4,4; no drop or dup; `_0` stable while stalled; `_done` only after last accept.
- Reset mid-run after 3 tuples -> `_valid`=0 next edge, `_done`=1 after; `_start` with `_reset` both high -> new run starts. `_start` mid-run (20,23,1) -> 20,20,21,21,22,22 only.

Source files
------------

// File: rtl/dup_range_param.sv
// Range generator that walks range(base, limit, step) and yields every element
// COPIES times as (value, copy_index) over a ready/valid/done handshake.
module dup_range_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned COPIES = 2,
  parameter int unsigned IDXW   = 8
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic        [IDXW-1:0]  _1
);

  localparam int unsigned SUMW = WIDTH + 1;

  typedef enum logic [1:0] {
    ST_CHECK = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  i_q, i_d;
  logic signed [WIDTH-1:0]  lim_q, lim_d;
  logic signed [WIDTH-1:0]  stp_q, stp_d;
  logic        [IDXW-1:0]   k_q, k_d;
  logic                     ovf_q, ovf_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic signed [WIDTH-1:0]  out0_q, out0_d;
  logic        [IDXW-1:0]   out1_q, out1_d;

  logic        [SUMW-1:0]   sum;
  logic                     terminate;
  logic                     advance;
  logic                     last_copy;

  // Sign-extended add one bit wider so a wrap of i is detectable.
  always_comb begin
    sum = {i_q[WIDTH-1], i_q} + {stp_q[WIDTH-1], stp_q};
  end

  always_comb begin
    terminate = (stp_q == '0)
             || (!stp_q[WIDTH-1] && (i_q >= lim_q))
             || ( stp_q[WIDTH-1] && (i_q <= lim_q))
             || ovf_q;
    advance   = _ready || !valid_q;
    last_copy = (k_q == IDXW'(COPIES - 1));
  end

  // Next-state and registered-output logic; _start wins over everything.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    lim_d   = lim_q;
    stp_d   = stp_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    done_d  = done_q;
    out0_d  = out0_q;
    out1_d  = out1_q;

    if (_start) begin
      i_d     = base;
      lim_d   = limit;
      stp_d   = step;
      k_d     = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      state_d = ST_CHECK;
    end else if (advance) begin
      case (state_q)
        ST_CHECK: begin
          valid_d = 1'b0;
          if (terminate) begin
            state_d = ST_DONE;
          end else begin
            k_d     = '0;
            state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          out0_d  = i_q;
          out1_d  = k_q;
          valid_d = 1'b1;
          if (last_copy) begin
            i_d     = sum[WIDTH-1:0];
            ovf_d   = sum[WIDTH] ^ sum[WIDTH-1];
            state_d = ST_CHECK;
          end else begin
            k_d = k_q + IDXW'(1);
          end
        end
        ST_DONE: begin
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end
      endcase
    end
  end

  // Synchronous reset applies only when no start is requested in the same cycle.
  always_ff @(posedge _clock) begin
    if (_reset && !_start) begin
      state_q <= ST_DONE;
      i_q     <= '0;
      lim_q   <= '0;
      stp_q   <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      out0_q  <= '0;
      out1_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      lim_q   <= lim_d;
      stp_q   <= stp_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
    end
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _0     = out0_q;
  assign _1     = out1_q;

endmodule

// File: tb/tb_dup_range_param.sv
// Directed bench for dup_range_param: three parameterisations share the stimulus,
// a selector picks which one is being checked.
module tb_dup_range_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, ready;
  logic signed [31:0] drv_b, drv_l, drv_s;

  logic        v_a, d_a, v_b, d_b, v_c, d_c;
  logic [31:0] o0_a, o0_b;
  logic [7:0]  o0_c;
  logic [7:0]  o1_a, o1_b, o1_c;

  // a: WIDTH=32 COPIES=2, b: WIDTH=32 COPIES=1, c: WIDTH=8 COPIES=1
  dup_range_param #(.WIDTH(32), .COPIES(2), .IDXW(8)) u_a (
    ._clock(clk), ._reset(rst), ._start(start), .base(drv_b), .limit(drv_l), .step(drv_s),
    ._ready(ready), ._valid(v_a), ._done(d_a), ._0(o0_a), ._1(o1_a));
  dup_range_param #(.WIDTH(32), .COPIES(1), .IDXW(8)) u_b (
    ._clock(clk), ._reset(rst), ._start(start), .base(drv_b), .limit(drv_l), .step(drv_s),
    ._ready(ready), ._valid(v_b), ._done(d_b), ._0(o0_b), ._1(o1_b));
  dup_range_param #(.WIDTH(8), .COPIES(1), .IDXW(8)) u_c (
    ._clock(clk), ._reset(rst), ._start(start), .base(drv_b[7:0]), .limit(drv_l[7:0]),
    .step(drv_s[7:0]), ._ready(ready), ._valid(v_c), ._done(d_c), ._0(o0_c), ._1(o1_c));

  int          sel;
  logic        cv, cd;
  logic [31:0] c0;
  logic [7:0]  c1;

  always_comb begin
    cv = v_a; cd = d_a; c0 = o0_a; c1 = o1_a;
    case (sel)
      1: begin cv = v_b; cd = d_b; c0 = o0_b; c1 = o1_b; end
      2: begin cv = v_c; cd = d_c; c0 = {{24{o0_c[7]}}, o0_c}; c1 = o1_c; end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [1:0]       sel;
    logic [31:0]      b;
    logic [31:0]      l;
    logic [31:0]      s;
    logic [4:0]       n;
    logic [9:0][31:0] e0;
  } vec_t;

  vec_t vecs [8];
  int   tests = 0;
  int   fails = 0;
  int   got0 [16];
  int   got1 [16];
  int   got_n, first_valid, first_done;

  function automatic vec_t mk(input int sl, input int bi, input int li, input int si,
                              input int ni, input int x0 = 0, input int x1 = 0,
                              input int x2 = 0, input int x3 = 0, input int x4 = 0,
                              input int x5 = 0, input int x6 = 0, input int x7 = 0,
                              input int x8 = 0, input int x9 = 0);
    vec_t r;
    r = '0;
    r.sel = 2'(sl); r.b = 32'(bi); r.l = 32'(li); r.s = 32'(si); r.n = 5'(ni);
    r.e0[0] = 32'(x0); r.e0[1] = 32'(x1); r.e0[2] = 32'(x2); r.e0[3] = 32'(x3);
    r.e0[4] = 32'(x4); r.e0[5] = 32'(x5); r.e0[6] = 32'(x6); r.e0[7] = 32'(x7);
    r.e0[8] = 32'(x8); r.e0[9] = 32'(x9);
    return r;
  endfunction

  function automatic int copies_of(input int sl);
    return (sl == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept tuples with ready high until done, a tuple cap, or the cycle budget.
  task automatic collect(input int max_tuples, input int budget);
    got_n = 0; first_valid = -1; first_done = -1;
    ready = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick();
      if (cv && cd) check("valid_with_done", 1, 0);
      if (cv) begin
        if (first_valid < 0) first_valid = cyc;
        if (got_n < 16) begin
          got0[got_n] = int'(c0);
          got1[got_n] = int'(c1);
        end
        got_n++;
      end
      if (cd) begin
        first_done = cyc;
        break;
      end
      if (got_n >= max_tuples) break;
    end
    if (first_done < 0 && got_n < max_tuples) check("collect_timeout", 0, 1);
  endtask

  task automatic start_run(input int sl, input int bi, input int li, input int si);
    sel = sl; drv_b = bi; drv_l = li; drv_s = si;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    start_run(int'(v.sel), int'(v.b), int'(v.l), int'(v.s));
    collect(99, 80);
    check($sformatf("v%0d_count", idx), got_n, int'(v.n));
    for (int j = 0; j < int'(v.n) && j < got_n; j++) begin
      check($sformatf("v%0d_val%0d", idx, j), got0[j], int'(v.e0[j]));
      check($sformatf("v%0d_idx%0d", idx, j), got1[j], j % copies_of(int'(v.sel)));
    end
    if (v.n != 0) check($sformatf("v%0d_first_valid_lat", idx), first_valid, 2);
    else          check($sformatf("v%0d_done_lat", idx), first_done, 2);
    repeat (3) tick();
    check($sformatf("v%0d_done_held", idx), int'({cd, cv}), 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  bp_prev0, bp_prev1;
    logic bp_stalled, bp_done_seen;
    int  bp_exp [6];

    vecs[0] = mk(0, 0, 10, 2, 10, 0, 0, 2, 2, 4, 4, 6, 6, 8, 8);
    vecs[1] = mk(1, 10, 0, -3, 4, 10, 7, 4, 1);
    vecs[2] = mk(1, 5, 5, 1, 0);
    vecs[3] = mk(1, 3, 9, 0, 0);
    vecs[4] = mk(2, 100, 127, 20, 2, 100, 120);
    vecs[5] = mk(0, -3, 2, 2, 6, -3, -3, -1, -1, 1, 1);
    vecs[6] = mk(0, 2147483640, 2147483647, 5, 4,
                 2147483640, 2147483640, 2147483645, 2147483645);
    vecs[7] = mk(1, -5, -9, -1, 4, -5, -6, -7, -8);

    // Reset state, then done rises on the first advancing edge after release.
    sel = 0; rst = 1'b1; start = 1'b0; ready = 1'b1;
    drv_b = 0; drv_l = 0; drv_s = 0;
    tick(); tick();
    check("rst_valid", int'(cv), 0);
    check("rst_done", int'(cd), 0);
    check("rst_out0", int'(c0), 0);
    check("rst_out1", int'(c1), 0);
    rst = 1'b0;
    tick();
    check("rst_done_rise", int'(cd), 1);

    for (int t = 0; t < 8; t++) run_vec(t, vecs[t]);

    // Backpressure with ready pattern 1,0,0,1 repeating.
    bp_exp = '{0, 0, 2, 2, 4, 4};
    start_run(0, 0, 6, 2);
    got_n = 0; bp_stalled = 1'b0; bp_done_seen = 1'b0; bp_prev0 = 0; bp_prev1 = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (bp_stalled) begin
        check("bp_hold_valid", int'(cv), 1);
        check("bp_hold_0", int'(c0), bp_prev0);
        check("bp_hold_1", int'(c1), bp_prev1);
      end
      if (cv && cd) check("bp_valid_with_done", 1, 0);
      if (cd) begin
        check("bp_done_after_last", got_n, 6);
        bp_done_seen = 1'b1;
        break;
      end
      ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      bp_stalled = cv && !ready;
      bp_prev0 = int'(c0);
      bp_prev1 = int'(c1);
      if (cv && ready) begin
        if (got_n < 16) begin
          got0[got_n] = int'(c0);
          got1[got_n] = int'(c1);
        end
        got_n++;
      end
      tick();
    end
    if (!bp_done_seen) check("bp_timeout", 0, 1);
    check("bp_count", got_n, 6);
    for (int j = 0; j < 6 && j < got_n; j++) begin
      check($sformatf("bp_val%0d", j), got0[j], bp_exp[j]);
      check($sformatf("bp_idx%0d", j), got1[j], j % 2);
    end
    ready = 1'b1;

    // Reset after three tuples.
    start_run(0, 0, 10, 2);
    collect(3, 40);
    check("mr_count", got_n, 3);
    check("mr_val2", got0[2], 2);
    rst = 1'b1;
    tick();
    check("mr_valid_cleared", int'(cv), 0);
    check("mr_done_low", int'(cd), 0);
    rst = 1'b0;
    tick();
    check("mr_done_rise", int'(cd), 1);

    // Start and reset together: start wins.
    sel = 0; drv_b = 4; drv_l = 6; drv_s = 1;
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("sr_done_low", int'(cd), 0);
    collect(99, 40);
    check("sr_count", got_n, 4);
    check("sr_first_lat", first_valid, 2);
    check("sr_val0", got0[0], 4);
    check("sr_val3", got0[3], 5);
    check("sr_idx3", got1[3], 1);

    // Restart mid-run: remaining tuples of the old run are discarded.
    start_run(0, 0, 10, 2);
    collect(2, 40);
    check("rs_pre_count", got_n, 2);
    start_run(0, 20, 23, 1);
    check("rs_valid_dropped", int'(cv), 0);
    collect(99, 60);
    check("rs_count", got_n, 6);
    for (int j = 0; j < 6 && j < got_n; j++) begin
      check($sformatf("rs_val%0d", j), got0[j], 20 + j / 2);
      check($sformatf("rs_idx%0d", j), got1[j], j % 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
